bin_clock_param: RTL and testbench
==================================

// Module: bin_clock_param
// PURPOSE
//   Parametrised second-generation binary clock core: hh:mm:ss counters driven by an internal
//   prescaler, runtime 12/24-hour display mode, AM/PM flag, and a set mode with
//   edge-detected, auto-repeating per-field increment/decrement. Sits beneath the TT top wrapper,
//   which maps its outputs onto LED pins.
// PARAMETERS
//   CLK_DIV      10_000_000  clk_i cycles per 1 s tick (>=2)
//   REPEAT_DLY   5_000_000   cycles a set button is held before auto-repeat starts; 0 = no repeat
//   REPEAT_PER   2_500_000   cycles between repeat steps once repeating (>=1)
//   RESET_HOUR   0           internal hour (0..23) loaded on reset
// PORTS
//   clk_i        in   1  system clock
//   rst_i        in   1  asynchronous, active-high reset
//   time_set_i   in   1  1 = set mode (time frozen, buttons active), 0 = run
//   inc_i        in   1  set direction: 1 = increment, 0 = decrement
//   hour_btn_i   in   1  raw hour button (async, active high)
//   min_btn_i    in   1  raw minute button
//   sec_btn_i    in   1  raw second button
//   mode24_i     in   1  1 = 24 h display, 0 = 12 h display
//   hour_o       out  5  displayed hour: 0..23 (24 h) or 1..12 (12 h)
//   minute_o     out  6  minute 0..59
//   second_o     out  6  second 0..59
//   pm_o         out  1  1 when internal hour >= 12 (both modes)
//   tick_o       out  1  one-cycle pulse on each 1 s tick
// BEHAVIOUR
//   Reset (async assert, sync deassert is the wrapper's job): prescaler=0, sec=0, min=0,
//     hour=RESET_HOUR, sync/repeat state cleared, tick_o=0. RESET_HOUR=0 -> 12 h shows 12, pm_o=0.
//   Internal hour always 0..23. 12 h map: 0->12, 1..12->same, 13..23->h-12. Output map combinational
//     from registered counters; mode24_i change takes effect same cycle, no counter change.
//   Prescaler: counts 0..CLK_DIV-1; on CLK_DIV-1 wraps to 0 and tick_o=1 that cycle (registered).
//   Run mode (time_set_i=0): on tick, sec+1; sec 59->0 carries min+1; min 59->0 carries hour+1;
//     hour 23->0. 23:59:59 + tick -> 00:00:00 in one cycle. Buttons ignored (sync chain still runs).
//   Set mode (time_set_i=1): prescaler held at 0, tick_o=0, no carries. Each button step moves
//     only its own field by +/-1 per inc_i, wrapping in-field (sec/min 0<->59, hour 0<->23).
//   Buttons: 2-FF synchroniser then rising-edge detect. Raw rise sampled at edge k -> field
//     updated at edge k+2 (visible after 3rd sampling edge). Release needs no action.
//   Auto-repeat (REPEAT_DLY>0): one shared hold counter per button; held continuously REPEAT_DLY
//     cycles after the step -> another step, then every REPEAT_PER cycles while held. Release or
//     leaving set mode clears that counter.
//   Simultaneous presses: each field steps independently in the same cycle.
//   Entering run mode: prescaler restarts from 0, so first tick CLK_DIV cycles after exit.
//   inc_i is sampled (via its own 2-FF sync) at the step cycle; no edge detect.
//   Reset mid-operation: all state returns to reset values immediately; no partial step survives.
// STRUCTURE
//   Package bin_clock_pkg: HOUR_W=5, MIN_W=6, SEC_W=6, MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23,
//     function to_12h(hour) returning 1..12.
//   Sub-module bin_clock_btn (instantiated x3): synchroniser + edge detect + repeat timer, outputs
//     one-cycle step pulse. Counters, prescaler and mapping stay in bin_clock_param.
// TESTING (bench uses CLK_DIV=4, REPEAT_DLY=8, REPEAT_PER=3, RESET_HOUR=0)
//   Reset, run 4 cycles, mode24_i=0 -> hour_o=12, pm_o=0, second_o=1, one tick_o pulse.
//   Set 23:59:58 via buttons, run 8 cycles -> 23:59:59 then 00:00:00, pm_o 1->0, hour_o(12h) 11->12.
//   Set mode, inc_i=0, single sec press at 00 -> second_o=59, minute_o unchanged; raw rise to
//     output change exactly 3 edges.
//   Hold min_btn_i 20 cycles, inc_i=1, from 0 -> steps at +2,+10,+13,+16,+19: minute_o=5.
//   All three buttons pressed same cycle, inc_i=1 at 11:59:59 -> 12:00:00, no carries, pm_o=1.
//   Assert rst_i mid-hold and mid-prescale -> all outputs reset values same cycle; no step after release.

Source files
------------

// File: rtl/bin_clock_pkg.sv
// Shared widths, field limits and helpers for the binary clock core.
package bin_clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int MAX_SEC  = 59;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;

  // One step request per settable field.
  typedef struct packed {
    logic hour;
    logic min;
    logic sec;
  } step_t;

  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour);
    if (hour == '0)                      return HOUR_W'(12);
    else if (hour > HOUR_W'(12))         return hour - HOUR_W'(12);
    else                                 return hour;
  endfunction

  // +/-1 with in-field wrap; hour is carried zero-extended to 6 bits.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0)  ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/bin_clock_btn.sv
// Set-button front end: 2-FF sync, rising-edge detect and hold-to-repeat timer.
module bin_clock_btn
  import bin_clock_pkg::*;
#(
  parameter int REPEAT_DLY = 5_000_000,
  parameter int REPEAT_PER = 2_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic btn_i,
  output logic step_o
);

  // [0],[1] synchroniser, [2] previous synchronised level.
  logic [2:0] sync_q;
  logic       rise, held, rep;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], btn_i};
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign held = sync_q[1] &  sync_q[2];

  generate
    if (REPEAT_DLY > 0) begin : g_rep
      localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

      logic [CNT_W-1:0] cnt_q;
      logic             armed_q;

      // Down-counter reloads on every step; a step fires when it reaches zero while held.
      assign rep = en_i & held & armed_q & (cnt_q == '0);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q   <= '0;
          armed_q <= 1'b0;
        end else if (!en_i || !sync_q[1]) begin
          cnt_q   <= '0;
          armed_q <= 1'b0;
        end else if (rise) begin
          cnt_q   <= CNT_W'(REPEAT_DLY - 1);
          armed_q <= 1'b1;
        end else if (rep) begin
          cnt_q   <= CNT_W'(REPEAT_PER - 1);
        end else if (cnt_q != '0) begin
          cnt_q   <= cnt_q - 1'b1;
        end
      end
    end else begin : g_norep
      assign rep = 1'b0;
    end
  endgenerate

  assign step_o = en_i & (rise | rep);

endmodule

// File: rtl/bin_clock_param.sv
// Binary clock core: prescaled hh:mm:ss counters, 12/24 h display and button time-set.
module bin_clock_param
  import bin_clock_pkg::*;
#(
  parameter int CLK_DIV    = 10_000_000,
  parameter int REPEAT_DLY = 5_000_000,
  parameter int REPEAT_PER = 2_500_000,
  parameter int RESET_HOUR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              time_set_i,
  input  logic              inc_i,
  input  logic              hour_btn_i,
  input  logic              min_btn_i,
  input  logic              sec_btn_i,
  input  logic              mode24_i,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  minute_o,
  output logic [SEC_W-1:0]  second_o,
  output logic              pm_o,
  output logic              tick_o
);

  localparam int PRE_W = $clog2(CLK_DIV);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              tick_q, tick_d;
  logic [1:0]        inc_sync_q;
  logic              wrap;
  logic [5:0]        hour_nx;
  step_t             step;

  bin_clock_btn #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_btn [2:0] (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (time_set_i),
    .btn_i  ({hour_btn_i, min_btn_i, sec_btn_i}),
    .step_o ({step.hour, step.min, step.sec})
  );

  assign wrap = (pre_q == PRE_W'(CLK_DIV - 1));

  always_comb begin
    pre_d   = pre_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_d  = 1'b0;
    hour_nx = 6'd0;
    if (time_set_i) begin
      pre_d = '0;
      if (step.sec) sec_d = step_wrap(sec_q, 6'(MAX_SEC), inc_sync_q[1]);
      if (step.min) min_d = step_wrap(min_q, 6'(MAX_MIN), inc_sync_q[1]);
      if (step.hour) begin
        hour_nx = step_wrap({1'b0, hour_q}, 6'(MAX_HOUR), inc_sync_q[1]);
        hour_d  = hour_nx[HOUR_W-1:0];
      end
    end else if (wrap) begin
      pre_d  = '0;
      tick_d = 1'b1;
      sec_d  = step_wrap(sec_q, 6'(MAX_SEC), 1'b1);
      // Full ripple carry in one cycle so 23:59:59 rolls straight to 00:00:00.
      if (sec_q == SEC_W'(MAX_SEC)) begin
        min_d = step_wrap(min_q, 6'(MAX_MIN), 1'b1);
        if (min_q == MIN_W'(MAX_MIN)) begin
          hour_nx = step_wrap({1'b0, hour_q}, 6'(MAX_HOUR), 1'b1);
          hour_d  = hour_nx[HOUR_W-1:0];
        end
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= HOUR_W'(RESET_HOUR);
      tick_q     <= 1'b0;
      inc_sync_q <= '0;
    end else begin
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      tick_q     <= tick_d;
      inc_sync_q <= {inc_sync_q[0], inc_i};
    end
  end

  assign hour_o   = mode24_i ? hour_q : to_12h(hour_q);
  assign minute_o = min_q;
  assign second_o = sec_q;
  assign pm_o     = (hour_q >= HOUR_W'(12));
  assign tick_o   = tick_q;

endmodule

// File: tb/tb_bin_clock_param.sv
// Directed bench for bin_clock_param with small prescale/repeat parameters.
module tb_bin_clock_param;

  logic       clk = 1'b0;
  logic       rst, time_set, inc, hour_btn, min_btn, sec_btn, mode24;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic       pm, tick;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tick_cnt;

  always #5 clk = ~clk;

  bin_clock_param #(.CLK_DIV(4), .REPEAT_DLY(8), .REPEAT_PER(3), .RESET_HOUR(0)) dut (
    .clk_i(clk), .rst_i(rst), .time_set_i(time_set), .inc_i(inc),
    .hour_btn_i(hour_btn), .min_btn_i(min_btn), .sec_btn_i(sec_btn), .mode24_i(mode24),
    .hour_o(hour), .minute_o(minute), .second_o(second), .pm_o(pm), .tick_o(tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; time_set = 1'b0; inc = 1'b0; mode24 = 1'b0;
    hour_btn = 1'b0; min_btn = 1'b0; sec_btn = 1'b0;
    #1;
    chk("rst_hour12", hour, 12);
    chk("rst_pm", pm, 0);
    chk("rst_sec", second, 0);
    chk("rst_tick", tick, 0);

    // Free run: first tick after 4 edges
    @(negedge clk) rst = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick_cnt += int'(tick);
    end
    chk("run_sec1", second, 1);
    chk("run_ticks", tick_cnt, 1);
    chk("run_hour12", hour, 12);
    mode24 = 1'b1; #1;
    chk("mode24_hour", hour, 0);

    // Set 23:59:58 by decrementing from 00:00:00
    @(negedge clk) rst = 1'b1;
    #1 rst = 1'b0;
    time_set = 1'b1; inc = 1'b0;
    cyc(3);
    hour_btn = 1'b1; min_btn = 1'b1; sec_btn = 1'b1;
    cyc(1);
    hour_btn = 1'b0; min_btn = 1'b0; sec_btn = 1'b0;
    cyc(3);
    sec_btn = 1'b1;
    cyc(1);
    sec_btn = 1'b0;
    cyc(3);
    chk("set_hour23", hour, 23);
    chk("set_min59", minute, 59);
    chk("set_sec58", second, 58);
    chk("set_no_tick", tick, 0);
    mode24 = 1'b0; time_set = 1'b0;
    cyc(4);
    chk("roll_sec59", second, 59);
    chk("roll_tick1", tick, 1);
    chk("roll_h12_11", hour, 11);
    chk("roll_pm1", pm, 1);
    cyc(4);
    chk("midnight_sec", second, 0);
    chk("midnight_min", minute, 0);
    chk("midnight_h12", hour, 12);
    chk("midnight_pm0", pm, 0);

    // Single decrement press: exactly 3 edges to output change
    time_set = 1'b1; sec_btn = 1'b1;
    cyc(1); chk("lat_e1", second, 0);
    cyc(1); chk("lat_e2", second, 0);
    cyc(1); chk("lat_e3", second, 59);
    chk("lat_min", minute, 0);
    sec_btn = 1'b0;

    // Hold minute 20 cycles: steps at +2,+10,+13,+16,+19
    inc = 1'b1;
    cyc(3);
    min_btn = 1'b1;
    cyc(3);  chk("hold_p2", minute, 1);
    cyc(7);  chk("hold_p9", minute, 1);
    cyc(1);  chk("hold_p10", minute, 2);
    cyc(9);  chk("hold_p19", minute, 5);
    min_btn = 1'b0;
    cyc(6);  chk("hold_after", minute, 5);
    chk("hold_sec", second, 59);

    // Build 11:59:59, then step all three together
    @(negedge clk) rst = 1'b1;
    #1 rst = 1'b0;
    inc = 1'b0;
    cyc(3);
    min_btn = 1'b1; sec_btn = 1'b1;
    cyc(1);
    min_btn = 1'b0; sec_btn = 1'b0;
    inc = 1'b1;
    cyc(3);
    hour_btn = 1'b1;
    cyc(37);
    hour_btn = 1'b0;
    cyc(5);
    chk("pre_hour11", hour, 11);
    chk("pre_min59", minute, 59);
    chk("pre_sec59", second, 59);
    chk("pre_pm0", pm, 0);
    hour_btn = 1'b1; min_btn = 1'b1; sec_btn = 1'b1;
    cyc(1);
    hour_btn = 1'b0; min_btn = 1'b0; sec_btn = 1'b0;
    cyc(3);
    chk("all_hour12", hour, 12);
    chk("all_min0", minute, 0);
    chk("all_sec0", second, 0);
    chk("all_pm1", pm, 1);
    mode24 = 1'b1; #1;
    chk("all_h24", hour, 12);

    // Reset mid-prescale
    time_set = 1'b0;
    cyc(2);
    rst = 1'b1; #1;
    chk("rstmid_hour", hour, 0);
    chk("rstmid_pm", pm, 0);
    chk("rstmid_tick", tick, 0);
    @(negedge clk) rst = 1'b0;

    // Reset mid-hold: no step survives release
    time_set = 1'b1; inc = 1'b1;
    cyc(3);
    sec_btn = 1'b1;
    cyc(5);
    chk("hold_pre_rst", second, 1);
    rst = 1'b1; #1;
    chk("rsthold_sec", second, 0);
    sec_btn = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(12);
    chk("post_rst_sec", second, 0);
    chk("post_rst_min", minute, 0);
    chk("post_rst_hour", hour, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
